// File: rtl/voice_allocator_if.sv
// rtl/voice_allocator_if.sv - note event handshake and voice register bus bundle
interface voice_allocator_if;
  logic        NoteValid;
  logic        NoteReady;
  logic        NoteOn;
  logic [6:0]  NoteKey;
  logic [23:0] NoteIncr;
  logic [15:0] BusAddress;
  logic [7:0]  BusWriteData;
  logic        BusReadWrite;
  logic        BusClock;

  // event source / bus observer side
  modport master (
    output NoteValid, NoteOn, NoteKey, NoteIncr,
    input  NoteReady, BusAddress, BusWriteData, BusReadWrite, BusClock
  );

  // allocator side
  modport slave (
    input  NoteValid, NoteOn, NoteKey, NoteIncr,
    output NoteReady, BusAddress, BusWriteData, BusReadWrite, BusClock
  );
endinterface

// File: rtl/voice_allocator.sv
// rtl/voice_allocator.sv - polyphonic note scheduler programming voice registers over a byte bus
module voice_allocator #(
  parameter int          NUM_VOICES   = 4,
  parameter logic [15:0] VOICE_BASE   = 16'h0010,
  parameter logic [15:0] VOICE_STRIDE = 16'h0020,
  parameter int          BUS_HALF     = 2
) (
  input  logic                  Clock,
  input  logic                  Reset,
  voice_allocator_if.slave      bus,
  input  logic [NUM_VOICES-1:0] VoiceActive,
  output logic [NUM_VOICES-1:0] VoiceHeld,
  output logic                  Busy
);

  localparam int VW = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
  localparam int CW = (2 * BUS_HALF > 2) ? $clog2(2 * BUS_HALF) : 1;
  localparam logic [CW-1:0] HALF_LAST = CW'(BUS_HALF - 1);
  localparam logic [CW-1:0] WIN_LAST  = CW'(2 * BUS_HALF - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ALLOC = 2'd1;
  localparam logic [1:0] S_WRITE = 2'd2;

  // Write slots: 0 = gate off, 1..3 = incr bytes, 4 = gate on.
  localparam logic [2:0] SLOT_GATE_OFF = 3'd0;
  localparam logic [2:0] SLOT_INCR_LO  = 3'd1;
  localparam logic [2:0] SLOT_GATE_ON  = 3'd4;

  logic [1:0]            state;
  logic                  ev_on;
  logic [6:0]            ev_key;
  logic [23:0]           ev_incr;

  logic [NUM_VOICES-1:0] held;
  logic [6:0]            key_r [NUM_VOICES];
  logic [7:0]            age_r [NUM_VOICES];

  logic [15:0]           wr_base;
  logic [2:0]            seq;
  logic [2:0]            seq_last;
  logic [CW-1:0]         cnt;

  logic                  on_found;
  logic [VW-1:0]         on_sel;
  logic                  on_prefix;
  logic [7:0]            best_age;
  logic                  off_found;
  logic [VW-1:0]         off_sel;
  logic [15:0]           on_base;
  logic [15:0]           off_base;
  logic [2:0]            on_first;
  logic [2:0]            seq_next;

  function automatic logic [7:0] slot_data(input logic [2:0] s, input logic [23:0] inc);
    logic [7:0] d;
    case (s)
      3'd1:    d = inc[7:0];
      3'd2:    d = inc[15:8];
      3'd3:    d = inc[23:16];
      3'd4:    d = 8'h01;
      default: d = 8'h00;
    endcase
    return d;
  endfunction

  function automatic logic [15:0] slot_offset(input logic [2:0] s);
    logic [15:0] o;
    if (s >= 3'd1 && s <= 3'd3) o = {13'd0, s};
    else                         o = 16'd0;
    return o;
  endfunction

  assign bus.NoteReady = (state == S_IDLE);
  assign Busy          = (state != S_IDLE);
  assign VoiceHeld     = held;

  // Note-on voice choice: retrigger, free idle, free releasing, then steal oldest held.
  always_comb begin
    on_found  = 1'b0;
    on_sel    = '0;
    on_prefix = 1'b0;
    best_age  = 8'd0;
    for (int i = 0; i < NUM_VOICES; i++) begin
      if (!on_found && held[i] && key_r[i] == ev_key) begin
        on_found  = 1'b1;
        on_sel    = VW'(i);
        on_prefix = 1'b1;
      end
    end
    for (int i = 0; i < NUM_VOICES; i++) begin
      if (!on_found && !held[i] && !VoiceActive[i]) begin
        on_found = 1'b1;
        on_sel   = VW'(i);
      end
    end
    for (int i = 0; i < NUM_VOICES; i++) begin
      if (!on_found && !held[i]) begin
        on_found = 1'b1;
        on_sel   = VW'(i);
      end
    end
    if (!on_found) begin
      // Everything is held here; strict compare keeps the lowest index on age ties.
      for (int i = 0; i < NUM_VOICES; i++) begin
        if (held[i] && (!on_found || age_r[i] > best_age)) begin
          on_found  = 1'b1;
          on_sel    = VW'(i);
          best_age  = age_r[i];
          on_prefix = 1'b1;
        end
      end
    end
  end

  // Note-off owner lookup: lowest-index held voice playing the released key.
  always_comb begin
    off_found = 1'b0;
    off_sel   = '0;
    for (int i = 0; i < NUM_VOICES; i++) begin
      if (!off_found && held[i] && key_r[i] == ev_key) begin
        off_found = 1'b1;
        off_sel   = VW'(i);
      end
    end
  end

  // Register base addresses wrap modulo 2^16.
  always_comb begin
    on_base  = VOICE_BASE + VOICE_STRIDE * 16'(on_sel);
    off_base = VOICE_BASE + VOICE_STRIDE * 16'(off_sel);
    on_first = on_prefix ? SLOT_GATE_OFF : SLOT_INCR_LO;
    seq_next = seq + 3'd1;
  end

  // Voice ownership table; only changes in the allocation cycle.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      held <= '0;
      for (int i = 0; i < NUM_VOICES; i++) begin
        key_r[i] <= 7'd0;
        age_r[i] <= 8'd0;
      end
    end else if (state == S_ALLOC) begin
      if (ev_on) begin
        for (int i = 0; i < NUM_VOICES; i++) begin
          if (held[i] && VW'(i) != on_sel && age_r[i] != 8'hFF) begin
            age_r[i] <= age_r[i] + 8'd1;
          end
        end
        held[on_sel]  <= 1'b1;
        key_r[on_sel] <= ev_key;
        age_r[on_sel] <= 8'd0;
      end else if (off_found) begin
        held[off_sel] <= 1'b0;
      end
    end
  end

  // Event capture, sequencing and byte-write strobe generation.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state            <= S_IDLE;
      ev_on            <= 1'b0;
      ev_key           <= 7'd0;
      ev_incr          <= 24'd0;
      wr_base          <= 16'd0;
      seq              <= 3'd0;
      seq_last         <= 3'd0;
      cnt              <= '0;
      bus.BusAddress   <= 16'd0;
      bus.BusWriteData <= 8'd0;
      bus.BusReadWrite <= 1'b0;
      bus.BusClock     <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.NoteValid) begin
            ev_on   <= bus.NoteOn;
            ev_key  <= bus.NoteKey;
            ev_incr <= bus.NoteIncr;
            state   <= S_ALLOC;
          end
        end
        S_ALLOC: begin
          if (ev_on) begin
            wr_base          <= on_base;
            seq              <= on_first;
            seq_last         <= SLOT_GATE_ON;
            cnt              <= '0;
            bus.BusAddress   <= on_base + slot_offset(on_first);
            bus.BusWriteData <= slot_data(on_first, ev_incr);
            bus.BusReadWrite <= 1'b1;
            bus.BusClock     <= 1'b1;
            state            <= S_WRITE;
          end else if (off_found) begin
            wr_base          <= off_base;
            seq              <= SLOT_GATE_OFF;
            seq_last         <= SLOT_GATE_OFF;
            cnt              <= '0;
            bus.BusAddress   <= off_base;
            bus.BusWriteData <= 8'h00;
            bus.BusReadWrite <= 1'b1;
            bus.BusClock     <= 1'b1;
            state            <= S_WRITE;
          end else begin
            state <= S_IDLE;
          end
        end
        S_WRITE: begin
          if (cnt == WIN_LAST) begin
            if (seq == seq_last) begin
              bus.BusAddress   <= 16'd0;
              bus.BusWriteData <= 8'd0;
              bus.BusReadWrite <= 1'b0;
              bus.BusClock     <= 1'b0;
              state            <= S_IDLE;
            end else begin
              seq              <= seq_next;
              cnt              <= '0;
              bus.BusAddress   <= wr_base + slot_offset(seq_next);
              bus.BusWriteData <= slot_data(seq_next, ev_incr);
              bus.BusClock     <= 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
            if (cnt == HALF_LAST) bus.BusClock <= 1'b0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_voice_allocator.sv
// tb/tb_voice_allocator.sv - directed and randomized check of voice_allocator against a voice table model
module tb_voice_allocator;
  localparam int NV = 4;
  localparam int BH = 2;

  logic          Clock = 1'b0;
  logic          Reset;
  logic [NV-1:0] VoiceActive;
  logic [NV-1:0] VoiceHeld;
  logic          Busy;

  voice_allocator_if vif();

  voice_allocator #(.NUM_VOICES(NV), .BUS_HALF(BH)) dut (
    .Clock       (Clock),
    .Reset       (Reset),
    .bus         (vif.slave),
    .VoiceActive (VoiceActive),
    .VoiceHeld   (VoiceHeld),
    .Busy        (Busy)
  );

  always #5 Clock = ~Clock;

  int total = 0;
  int bad   = 0;

  bit          m_held [NV];
  int          m_key  [NV];
  int          m_age  [NV];
  logic [15:0] exp_a [$];
  logic [7:0]  exp_d [$];
  logic [15:0] got_a [$];
  logic [7:0]  got_d [$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] vbase(input int v);
    return 16'h0010 + 16'(v * 32);
  endfunction

  function automatic logic [NV-1:0] m_held_vec();
    logic [NV-1:0] h;
    for (int i = 0; i < NV; i++) h[i] = m_held[i];
    return h;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NV; i++) begin
      m_held[i] = 1'b0;
      m_key[i]  = 0;
      m_age[i]  = 0;
    end
  endtask

  task automatic model_event(input bit on, input int k, input logic [23:0] inc, input logic [NV-1:0] act);
    int v;
    bit pre;
    v   = -1;
    pre = 1'b0;
    exp_a.delete();
    exp_d.delete();
    if (on) begin
      for (int i = 0; i < NV; i++) if (v < 0 && m_held[i] && m_key[i] == k) begin v = i; pre = 1'b1; end
      for (int i = 0; i < NV; i++) if (v < 0 && !m_held[i] && !act[i]) v = i;
      for (int i = 0; i < NV; i++) if (v < 0 && !m_held[i]) v = i;
      if (v < 0) begin
        pre = 1'b1;
        v   = 0;
        for (int i = 1; i < NV; i++) if (m_age[i] > m_age[v]) v = i;
      end
      if (pre) begin exp_a.push_back(vbase(v)); exp_d.push_back(8'h00); end
      exp_a.push_back(vbase(v) + 16'd1); exp_d.push_back(inc[7:0]);
      exp_a.push_back(vbase(v) + 16'd2); exp_d.push_back(inc[15:8]);
      exp_a.push_back(vbase(v) + 16'd3); exp_d.push_back(inc[23:16]);
      exp_a.push_back(vbase(v));         exp_d.push_back(8'h01);
      for (int i = 0; i < NV; i++) if (i != v && m_held[i]) m_age[i] = (m_age[i] >= 255) ? 255 : m_age[i] + 1;
      m_held[v] = 1'b1;
      m_key[v]  = k;
      m_age[v]  = 0;
    end else begin
      for (int i = 0; i < NV; i++) if (v < 0 && m_held[i] && m_key[i] == k) v = i;
      if (v >= 0) begin
        m_held[v] = 1'b0;
        exp_a.push_back(vbase(v));
        exp_d.push_back(8'h00);
      end
    end
  endtask

  task automatic do_event(input bit on, input int k, input logic [23:0] inc, input logic [NV-1:0] act);
    int n;
    int j;
    int ph;
    logic [27:0] ev;
    logic [27:0] gv;
    model_event(on, k, inc, act);
    n = exp_a.size();
    got_a.delete();
    got_d.delete();
    @(negedge Clock);
    check("ready_idle", 64'(vif.NoteReady), 64'd1);
    vif.NoteValid = 1'b1;
    vif.NoteOn    = on;
    vif.NoteKey   = 7'(k);
    vif.NoteIncr  = inc;
    VoiceActive   = act;
    @(posedge Clock);
    #1 vif.NoteValid = 1'b0;
    @(negedge Clock);
    check("alloc", 64'({vif.NoteReady, Busy, vif.BusClock, vif.BusReadWrite}), 64'(4'b0100));
    for (int c = 0; c < n * 2 * BH; c++) begin
      @(negedge Clock);
      j  = c / (2 * BH);
      ph = c % (2 * BH);
      ev = {1'b0, 1'b1, (ph < BH), 1'b1, exp_a[j], exp_d[j]};
      gv = {vif.NoteReady, Busy, vif.BusClock, vif.BusReadWrite, vif.BusAddress, vif.BusWriteData};
      check("wr_cycle", 64'(gv), 64'(ev));
      if (ph == 0) begin
        got_a.push_back(vif.BusAddress);
        got_d.push_back(vif.BusWriteData);
      end
    end
    @(negedge Clock);
    gv = {vif.NoteReady, Busy, vif.BusClock, vif.BusReadWrite, vif.BusAddress, vif.BusWriteData};
    check("done", 64'(gv), 64'(28'h8000000));
    check("held", 64'(VoiceHeld), 64'(m_held_vec()));
  endtask

  task automatic do_reset();
    @(negedge Clock);
    Reset = 1'b1;
    #1;
    check("rst_out", 64'({vif.NoteReady, Busy, vif.BusClock, vif.BusReadWrite, vif.BusAddress, vif.BusWriteData}),
          64'(28'h8000000));
    check("rst_held", 64'(VoiceHeld), 64'd0);
    model_reset();
    @(negedge Clock);
    Reset = 1'b0;
  endtask

  logic [NV-1:0] held_before;

  initial begin
    Reset         = 1'b1;
    vif.NoteValid = 1'b0;
    vif.NoteOn    = 1'b0;
    vif.NoteKey   = 7'd0;
    vif.NoteIncr  = 24'd0;
    VoiceActive   = '0;
    model_reset();
    do_reset();

    do_event(1'b1, 60, 24'h0FFFFF, 4'b0000);
    check("e1_n", 64'(got_a.size()), 64'd4);
    check("e1_a0", 64'(got_a[0]), 64'h0011);
    check("e1_d0", 64'(got_d[0]), 64'hFF);
    check("e1_d2", 64'(got_d[2]), 64'h0F);
    check("e1_a3", 64'(got_a[3]), 64'h0010);
    check("e1_d3", 64'(got_d[3]), 64'h01);
    check("e1_held", 64'(VoiceHeld), 64'(4'b0001));

    do_event(1'b1, 64, 24'h00FFFF, 4'b0000);
    check("e2_a0", 64'(got_a[0]), 64'h0031);
    check("e2_d2", 64'(got_d[2]), 64'h00);
    check("e2_held", 64'(VoiceHeld), 64'(4'b0011));

    do_event(1'b0, 60, 24'h0, 4'b0000);
    check("off_n", 64'(got_a.size()), 64'd1);
    check("off_a", 64'(got_a[0]), 64'h0010);
    check("off_held", 64'(VoiceHeld), 64'(4'b0010));

    do_event(1'b0, 99, 24'h0, 4'b0000);
    check("miss_n", 64'(got_a.size()), 64'd0);

    do_reset();
    for (int i = 0; i < 4; i++) do_event(1'b1, 60 + i, 24'h123456 + 24'(i), 4'b1111);
    check("full", 64'(VoiceHeld), 64'(4'b1111));
    do_event(1'b1, 70, 24'hABCDEF, 4'b1111);
    check("steal_n", 64'(got_a.size()), 64'd5);
    check("steal_a0", 64'(got_a[0]), 64'h0010);
    check("steal_d0", 64'(got_d[0]), 64'h00);
    do_event(1'b0, 62, 24'h0, 4'b1111);
    do_event(1'b0, 63, 24'h0, 4'b1111);
    do_event(1'b1, 80, 24'h000102, 4'b0100);
    check("pref_a0", 64'(got_a[0]), 64'h0071);

    held_before = VoiceHeld;
    do_event(1'b1, 61, 24'h777777, 4'b1111);
    check("retrig_n", 64'(got_a.size()), 64'd5);
    check("retrig_a0", 64'(got_a[0]), 64'h0030);
    check("retrig_held", 64'(VoiceHeld), 64'(held_before));

    @(negedge Clock);
    vif.NoteValid = 1'b1;
    vif.NoteOn    = 1'b1;
    vif.NoteKey   = 7'd61;
    vif.NoteIncr  = 24'h010203;
    @(posedge Clock);
    #1 vif.NoteValid = 1'b0;
    repeat (1 + 2 * BH + 1) @(negedge Clock);
    check("mid_clk", 64'({vif.BusClock, vif.BusReadWrite}), 64'(2'b11));
    Reset = 1'b1;
    #1;
    check("mid_rst", 64'({vif.NoteReady, vif.BusClock, vif.BusReadWrite}), 64'(3'b100));
    check("mid_held", 64'(VoiceHeld), 64'd0);
    model_reset();
    @(negedge Clock);
    Reset = 1'b0;

    for (int e = 0; e < 300; e++) begin
      do_event($urandom_range(0, 9) < 6, 60 + $urandom_range(0, 9), 24'($urandom), 4'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
